// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Start/busy/done handshake bundle between the execute stage and the MDU.
interface mdu_if;
   logic        start;
   logic        flush;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] result;

   modport master (output start, flush, op, a, b, input busy, done, result);
   modport slave  (input start, flush, op, a, b, output busy, done, result);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring division iteration: trial-subtract divisor from the 33-bit partial remainder.
module mdu_div_step (
   input  logic [32:0] part,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic        qbit
);

   logic [33:0] diff;

   assign diff = {1'b0, part} - {2'b00, divisor};
   assign qbit = ~diff[33];
   // Either branch fits 32 bits: a kept difference is below the divisor, a restored part is too.
   assign rem_next = diff[33] ? part[31:0] : diff[31:0];

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit: multiply done in 2 cycles, divide in 34.
// Requests are only sampled while not busy; flush cancels without touching result.
module mdu
   import mdu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   mdu_if.slave bus
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      quo, rem, dvs;
   logic             neg_q, neg_r, sgn;
   logic [63:0]      result;

   logic accept, is_div, b_zero, last;
   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] prod;
   logic [31:0] step_rem;
   logic        step_q;

   assign accept = (state == IDLE || state == DONE) && bus.start && !bus.flush;
   assign is_div = bus.op[1];
   assign b_zero = (bus.b == 32'd0);
   assign last   = (cnt == CNT_W'(DIV_ITERS - 1));

   assign mul_a = {sgn & quo[31], quo};
   assign mul_b = {sgn & dvs[31], dvs};
   assign prod  = 66'(mul_a) * 66'(mul_b);

   mdu_div_step u_step (
      .part     ({rem, quo[31]}),
      .divisor  (dvs),
      .rem_next (step_rem),
      .qbit     (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Divide by zero passes through FIX so it shares the 2-cycle multiply timing.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (!accept)     state_nxt = IDLE;
            else if (!is_div) state_nxt = MUL;
            else if (b_zero)  state_nxt = FIX;
            else              state_nxt = DIV;
         end
         MUL:     state_nxt = DONE;
         DIV:     if (last) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         sgn    <= 1'b0;
         result <= '0;
      end else if (accept) begin
         cnt   <= '0;
         sgn   <= (bus.op == OP_MULT);
         neg_q <= (bus.op == OP_DIV) && !b_zero && (bus.a[31] ^ bus.b[31]);
         neg_r <= (bus.op == OP_DIV) && !b_zero && bus.a[31];
         dvs   <= (bus.op == OP_DIV) ? abs32(bus.b) : bus.b;
         if (is_div && b_zero) begin
            rem <= bus.a;
            quo <= 32'hFFFF_FFFF;
         end else begin
            rem <= '0;
            quo <= (bus.op == OP_DIV) ? abs32(bus.a) : bus.a;
         end
      end else if (!bus.flush) begin
         case (state)
            MUL: result <= prod[63:0];
            DIV: begin
               rem <= step_rem;
               quo <= {quo[30:0], step_q};
               cnt <= cnt + 1'b1;
            end
            FIX: result <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state == MUL) || (state == DIV) || (state == FIX);
   assign bus.done   = (state == DONE);
   assign bus.result = result;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table through a scoreboard plus control corner cases.
module tb_mdu;
   import mdu_pkg::*;

   logic clk;
   logic rst;
   mdu_if bus();

   mdu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      int          lat;
      string       name;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic run_one(input vec_t v);
      exp_t e;
      int   lat;
      int   busy_ok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = v.op;
      bus.a     = v.a;
      bus.b     = v.b;
      e.res = v.res;
      e.lat = v.lat;
      sb.push_back(e);
      @(posedge clk);
      lat     = -1;
      busy_ok = 1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (bus.busy !== (c < v.lat)) busy_ok = 0;
         if (bus.done === 1'b1) begin
            lat = c;
            break;
         end
      end
      e = sb.pop_front();
      chk_int({v.name, " latency"}, lat, e.lat);
      chk64({v.name, " result"}, bus.result, e.res);
      chk_int({v.name, " busy"}, busy_ok, 1);
   endtask

   vec_t        vecs[12];
   exp_t        e;
   logic [63:0] prev;
   int          busy_bad;
   int          saw_done;

   initial begin
      vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 2,  "mult_neg3x5"};
      vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2,  "multu_max"};
      vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2,  "mult_minxmin"};
      vecs[3]  = '{OP_MULTU, 32'h8000_0000, 32'd2,        64'h0000_0001_0000_0000, 2,  "multu_carry"};
      vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 34, "div_neg7_2"};
      vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,        64'h0000_0002_0000_000E, 34, "divu_100_7"};
      vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34, "div_min_m1"};
      vecs[7]  = '{OP_DIVU,  32'd100,       32'd0,        64'h0000_0064_FFFF_FFFF, 2,  "divu_by0"};
      vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34, "div_7_neg2"};
      vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 34, "div_neg7_neg2"};
      vecs[10] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        64'hFFFF_FFFB_FFFF_FFFF, 2,  "div_by0_neg"};
      vecs[11] = '{OP_DIVU,  32'd5,         32'h8000_0000, 64'h0000_0005_0000_0000, 34, "divu_small"};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk_int("reset busy", int'(bus.busy), 0);
      chk_int("reset done", int'(bus.done), 0);
      chk64("reset result", bus.result, 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_one(vecs[i]);

      // back-to-back: second start issued in the DONE cycle of the first
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5;
      e.res = 64'hFFFF_FFFF_FFFF_FFF1; e.lat = 2; sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk_int("b2b first busy", int'(bus.busy), 1);
      @(negedge clk);
      chk_int("b2b first done", int'(bus.done), 1);
      e = sb.pop_front();
      chk64("b2b first result", bus.result, e.res);
      bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd4;
      e.res = 64'd12; e.lat = 2; sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk_int("b2b second busy", int'(bus.busy), 1);
      chk_int("b2b second nodone", int'(bus.done), 0);
      @(negedge clk);
      chk_int("b2b second done", int'(bus.done), 1);
      e = sb.pop_front();
      chk64("b2b second result", bus.result, e.res);

      // ignored start in cycle 5, flush in cycle 10
      @(negedge clk);
      prev = bus.result;
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk);
      busy_bad = 0;
      saw_done = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c <= 10 && bus.busy !== 1'b1) busy_bad++;
         if (c >= 11 && bus.busy !== 1'b0) busy_bad++;
         if (bus.done === 1'b1) saw_done++;
         bus.start = (c == 5);
         if (c == 5) begin
            bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
         end
         bus.flush = (c == 10);
      end
      chk_int("flush busy profile", busy_bad, 0);
      chk_int("flush no done", saw_done, 0);
      chk64("flush result kept", bus.result, prev);

      // asynchronous reset in cycle 20 of a divide
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
      end
      chk_int("pre-reset busy", int'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk_int("mid reset busy", int'(bus.busy), 0);
      chk_int("mid reset done", int'(bus.done), 0);
      chk64("mid reset result", bus.result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_one('{OP_MULT, 32'd6, 32'd7, 64'd42, 2, "mult_after_reset"});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
